// File: rtl/kuz_l_transform_seq.sv
// kuz_l_transform_seq: sequential Kuznyechik L = R^16, log-domain multiply via external log ROM and internal antilog ROM
// Optional inverse mode (L^-1) with `inv` port when KUZ_L_INV_EN is defined
module kuz_l_transform_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef KUZ_L_INV_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [7:0]   log_addr,
  input  logic [7:0]   log_data
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [127:0] COEF = 128'h94_20_85_10_c2_c0_01_fb_01_c0_c2_10_85_20_94_01;
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'hc3 : 8'h00);
  endfunction
  function automatic logic [7:0] gf_exp(input logic [7:0] n);
    logic [7:0] x;
    x = 8'h01;
    for (int i = 0; i < 255; i++) if (i < int'(n)) x = xtime(x);
    return x;
  endfunction
  // log(1) comes out as 255, matching the external table's convention
  function automatic logic [7:0] gf_log(input logic [7:0] c);
    logic [7:0] x;
    logic [7:0] l;
    x = 8'h01;
    l = 8'h00;
    for (int i = 1; i < 256; i++) begin
      x = xtime(x);
      if (x == c && l == 8'h00) l = 8'(i);
    end
    return l;
  endfunction
  logic [7:0]   w_exp_rom [256];
  logic [7:0]   w_logc [16];
  for (genvar g = 0; g < 256; g++) begin : g_exp
    assign w_exp_rom[g] = gf_exp(8'(g));
  end
  for (genvar h = 0; h < 16; h++) begin : g_logc
    assign w_logc[h] = gf_log(COEF[127-8*h -: 8]);
  end
  logic [2:0]   r_state;
  logic [3:0]   r_cnt;
  logic [3:0]   r_round;
  logic [127:0] r_s;
  logic [127:0] r_out;
  logic [7:0]   r_acc;
  logic [7:0]   r_addr;
  logic         r_v1;
  logic         r_z1;
  logic [3:0]   r_k1;
  logic         r_v2;
  logic         r_z2;
  logic [7:0]   r_exp;
  logic         w_accept;
  logic         w_issue;
  logic         w_shift;
  logic [2:0]   w_nxt;
  logic [127:0] w_src;
  logic [127:0] w_next_s;
  logic [7:0]   w_byte;
  logic [8:0]   w_s9;
  logic [7:0]   w_r;
  logic [7:0]   w_p;
`ifdef KUZ_L_INV_EN
  logic         r_inv;
  assign w_src    = r_inv ? {r_s[119:0], r_s[127:120]} : r_s;
  assign w_next_s = r_inv ? {r_s[119:0], r_acc} : {r_acc, r_s[127:8]};
`else
  assign w_src    = r_s;
  assign w_next_s = {r_acc, r_s[127:8]};
`endif
  assign w_accept  = in_valid & in_ready;
  assign w_issue   = r_state == ISSUE;
  assign w_shift   = r_state == SHIFT;
  assign w_nxt     = (r_state == IDLE)  ? (w_accept ? ISSUE : IDLE) :
                     (r_state == ISSUE) ? (r_cnt == 4'd15 ? DRAIN : ISSUE) :
                     (r_state == DRAIN) ? (r_cnt == 4'd2 ? SHIFT : DRAIN) :
                     (r_state == SHIFT) ? (r_round == 4'd15 ? DONE : ISSUE) :
                     (r_state == DONE && !out_ready) ? DONE : IDLE;
  assign w_byte    = 8'(w_src >> {~r_cnt, 3'b000});
  assign w_s9      = {1'b0, log_data} + {1'b0, w_logc[r_k1]};
  assign w_r       = w_s9 >= 9'd510 ? 8'(w_s9 - 9'd510) : w_s9 >= 9'd255 ? 8'(w_s9 - 9'd255) : w_s9[7:0];
  assign w_p       = r_z2 ? 8'h00 : r_exp;
  assign log_addr  = w_issue ? w_byte : r_addr;
  assign in_ready  = r_state == IDLE && !rst;
  assign out_valid = r_state == DONE;
  assign out_data  = r_out;
  // byte k: address in cycle k, log back in k+1, antilog registered in k+2, accumulated at end of k+2
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_round <= 4'd0;
      r_s     <= '0;
      r_out   <= '0;
      r_acc   <= 8'h00;
      r_addr  <= 8'h00;
      r_v1    <= 1'b0;
      r_z1    <= 1'b0;
      r_k1    <= 4'd0;
      r_v2    <= 1'b0;
      r_z2    <= 1'b0;
      r_exp   <= 8'h00;
`ifdef KUZ_L_INV_EN
      r_inv   <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (w_nxt != r_state) ? 4'd0 : r_cnt + 4'd1;
      r_round <= w_accept ? 4'd0 : w_shift ? r_round + 4'd1 : r_round;
      r_s     <= w_accept ? in_data : w_shift ? w_next_s : r_s;
      r_out   <= (w_shift && r_round == 4'd15) ? w_next_s : r_out;
      r_acc   <= (w_issue && r_cnt == 4'd0) ? 8'h00 : r_v2 ? r_acc ^ w_p : r_acc;
      r_addr  <= log_addr;
      r_v1    <= w_issue;
      r_z1    <= w_byte == 8'h00;
      r_k1    <= r_cnt;
      r_v2    <= r_v1;
      r_z2    <= r_z1;
      r_exp   <= w_exp_rom[w_r];
`ifdef KUZ_L_INV_EN
      r_inv   <= w_accept ? inv : r_inv;
`endif
    end
  end
endmodule

// File: tb/tb_kuz_l_transform_seq.sv
// tb_kuz_l_transform_seq: scoreboard bench for kuz_l_transform_seq with a registered log-table ROM model
module tb_kuz_l_transform_seq;
  localparam logic [127:0] V0   = 128'h64a59400000000000000000000000000;
  localparam logic [127:0] D0   = 128'hd456584dd0e3e84cc3166e4b7fa2890d;
  localparam logic [127:0] D1   = 128'h79d26221b87b584cd42fbc4ffea5de9a;
  localparam logic [127:0] P    = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] COEF = 128'h94_20_85_10_c2_c0_01_fb_01_c0_c2_10_85_20_94_01;
  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [7:0]   log_addr;
  logic [7:0]   log_data;
`ifdef KUZ_L_INV_EN
  logic         inv;
`endif
  logic [7:0]   log_tab [256];
  logic [127:0] sb [$];
  int           ts [$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  logic         prev_rst = 1'b0;
  logic         prev_v = 1'b0;
  logic         prev_acc = 1'b0;
  kuz_l_transform_seq dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
`ifdef KUZ_L_INV_EN
    .inv(inv),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .log_addr(log_addr),
    .log_data(log_data)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    logic [7:0] x;
    x = 8'h01;
    log_tab[0] = 8'h00;
    for (int i = 1; i < 256; i++) begin
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hc3 : 8'h00);
      log_tab[x] = 8'(i);
    end
  end
  always @(posedge clk) log_data <= log_tab[log_addr];
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'hc3 : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [127:0] r_model(input logic [127:0] s);
    logic [7:0] l;
    l = 8'h00;
    for (int k = 0; k < 16; k++) l = l ^ gmul(s[127-8*k -: 8], COEF[127-8*k -: 8]);
    return {l, s[127:8]};
  endfunction
  function automatic logic [127:0] l_model(input logic [127:0] s);
    for (int i = 0; i < 16; i++) s = r_model(s);
    return s;
  endfunction
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  // monitor: all comparisons live here so the counters have a single writer
  always @(negedge clk) begin
    if (cyc == 1) begin
      chk("model_r", r_model(128'h0100), 128'h94000000000000000000000000000001);
      chk("model_l", l_model(V0), D0);
    end
    if (rst) begin
      chk("rst_in_ready", 128'(in_ready), 128'd0);
      if (prev_rst) begin
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
      end
      sb.delete();
      ts.delete();
    end else begin
      if (prev_rst || prev_acc) chk("idle_in_ready", 128'(in_ready), 128'd1);
      if (out_valid && !prev_v) begin
        if (ts.size() != 0) chk("latency", 128'(cyc - ts[0]), 128'd321);
        else chk("unexpected_valid", 128'(out_valid), 128'd0);
      end
      if (out_valid && !out_ready && sb.size() != 0) begin
        chk("hold_data", out_data, sb[0]);
        chk("hold_in_ready", 128'(in_ready), 128'd0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() != 0) begin
          chk("out_data", out_data, sb.pop_front());
          ts.delete(0);
        end else chk("unexpected_out", 128'(out_valid), 128'd0);
      end else if (ts.size() != 0 && cyc - ts[0] > 400) begin
        chk("timeout", 128'(out_valid), 128'd1);
        sb.delete(0);
        ts.delete(0);
      end
    end
    prev_rst <= rst;
    prev_v   <= out_valid && !rst;
    prev_acc <= out_valid && out_ready && !rst;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [127:0] d, input logic [127:0] e);
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    sb.push_back(e);
    ts.push_back(cyc);
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
  endtask
  task automatic wait_empty;
    for (int i = 0; i < 450 && sb.size() != 0; i++) tick();
  endtask
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef KUZ_L_INV_EN
    inv       = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    send(V0, D0);
    wait_empty();
    send('0, '0);
    wait_empty();
    send(128'h0100, l_model(128'h0100));
    wait_empty();
    send(D0, D1);
    wait_empty();
    send(P, l_model(P));
    wait_empty();
    out_ready = 1'b0;
    send(V0, D0);
    for (int i = 0; i < 400 && !out_valid; i++) tick();
    repeat (10) tick();
    out_ready = 1'b1;
    wait_empty();
    send('1, l_model('1));
    repeat (149) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (200) tick();
    send(V0, D0);
    wait_empty();
`ifdef KUZ_L_INV_EN
    inv = 1'b1;
    send(D0, V0);
    wait_empty();
    inv = 1'b0;
    send(V0, D0);
    wait_empty();
`endif
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
